// File: rtl/atconv_pool_param.sv
// Atrous 3x3 convolution with bias, ReLU and saturation over a square image,
// followed by an optional 2x2 stride-2 max-pool with round-up to whole units.
module atconv_pool_param #(
  parameter int IMG_LOG2 = 6,
  parameter int DATA_W   = 13,
  parameter int DIL      = 2,
  parameter int BIAS     = -12,
  parameter bit POOL_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  output logic                    busy,
  output logic [2*IMG_LOG2-1:0]   iaddr,
  input  logic [DATA_W-1:0]       idata,
  output logic                    cwr,
  output logic [2*IMG_LOG2-1:0]   caddr_wr,
  output logic [DATA_W-1:0]       cdata_wr,
  output logic                    crd,
  output logic [2*IMG_LOG2-1:0]   caddr_rd,
  input  logic [DATA_W-1:0]       cdata_rd,
  output logic                    csel
);
  localparam int AW    = 2 * IMG_LOG2;
  localparam int PW    = AW - 2;
  localparam int CW    = IMG_LOG2 + 2;
  localparam int ACC_W = DATA_W + 4;
  localparam logic signed [CW-1:0]    DIL_S  = CW'(DIL);
  localparam logic signed [CW-1:0]    CMAX   = CW'((1 << IMG_LOG2) - 1);
  localparam logic signed [ACC_W-1:0] VMAX   = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] BIAS_X = ACC_W'(BIAS);
  localparam logic [DATA_W-1:0]       RMAX   = {1'b0, {(DATA_W-5){1'b1}}, 4'b0000};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_CONV = 3'd2, S_WR0 = 3'd3,
    S_PFETCH = 3'd4, S_PWR = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_nx_s;
  logic [AW-1:0] pix_q, pix_d;
  logic [PW-1:0] pout_q, pout_d;
  logic busy_q, busy_d, cwr_q, cwr_d, crd_q, crd_d, csel_q, csel_d, tap_we_s;
  logic [AW-1:0] iaddr_q, iaddr_d, caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
  logic signed [DATA_W-1:0] max_q, max_d, mx_s;
  logic signed [DATA_W-1:0] taps_q [9];
  logic signed [ACC_W-1:0] acc_s;

  // Replicate padding: offset coordinate clamped into [0, N-1].
  function automatic logic [IMG_LOG2-1:0] clamp_coord(input logic [IMG_LOG2-1:0] base,
                                                      input logic [1:0] sel);
    logic signed [CW-1:0] v;
    case (sel)
      2'd0:    v = $signed({2'b00, base}) - DIL_S;
      2'd2:    v = $signed({2'b00, base}) + DIL_S;
      default: v = $signed({2'b00, base});
    endcase
    if (v[CW-1]) return '0;
    else if (v > CMAX) return '1;
    else return v[IMG_LOG2-1:0];
  endfunction

  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] pix, input logic [3:0] k);
    logic [3:0] dydx;
    case (k)
      4'd0: dydx = 4'b0000;  4'd1: dydx = 4'b0001;  4'd2: dydx = 4'b0010;
      4'd3: dydx = 4'b0100;  4'd4: dydx = 4'b0101;  4'd5: dydx = 4'b0110;
      4'd6: dydx = 4'b1000;  4'd7: dydx = 4'b1001;  4'd8: dydx = 4'b1010;
      default: dydx = 4'b0101;
    endcase
    return {clamp_coord(pix[AW-1:IMG_LOG2], dydx[3:2]), clamp_coord(pix[IMG_LOG2-1:0], dydx[1:0])};
  endfunction

  // Read p of pool window: row 2R+p[1], column 2C+p[0].
  function automatic logic [AW-1:0] pool_addr(input logic [PW-1:0] po, input logic [1:0] p);
    return {po[PW-1:IMG_LOG2-1], p[1], po[IMG_LOG2-2:0], p[0]};
  endfunction

  function automatic logic signed [ACC_W-1:0] ext(input logic signed [DATA_W-1:0] v);
    return {{4{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] relu_sat(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1]) return '0;
    else if (a > VMAX) return VMAX[DATA_W-1:0];
    else return a[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] round_up(input logic [DATA_W-1:0] m);
    logic [DATA_W-5:0] ip;
    ip = m[DATA_W-1:4] + (DATA_W-4)'(1);
    if (m[3:0] == 4'b0000) return m;
    else if (m >= RMAX) return RMAX;
    else return {ip, 4'b0000};
  endfunction

  assign cnt_nx_s = cnt_q + 4'd1;
  assign acc_s = ext(taps_q[4])
               - ext(taps_q[0] >>> 3'd4) - ext(taps_q[2] >>> 3'd4)
               - ext(taps_q[6] >>> 3'd4) - ext(taps_q[8] >>> 3'd4)
               - ext(taps_q[1] >>> 3'd3) - ext(taps_q[7] >>> 3'd3)
               - ext(taps_q[3] >>> 3'd2) - ext(taps_q[5] >>> 3'd2) + BIAS_X;
  // First read of a window seeds the running max.
  assign mx_s = (cnt_q == 4'd1 || $signed(cdata_rd) > max_q) ? $signed(cdata_rd) : max_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  pix_d = pix_q;  pout_d = pout_q;
    busy_d = busy_q;  iaddr_d = iaddr_q;  cwr_d = 1'b0;  crd_d = 1'b0;
    caddr_wr_d = caddr_wr_q;  cdata_wr_d = cdata_wr_q;  caddr_rd_d = caddr_rd_q;
    csel_d = csel_q;  max_d = max_q;  tap_we_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready) begin
          state_d = S_FETCH;  busy_d = 1'b1;  cnt_d = 4'd0;  pix_d = '0;  pout_d = '0;
          csel_d = 1'b0;  iaddr_d = tap_addr('0, 4'd0);
        end else begin
          busy_d = 1'b0;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_nx_s;
        tap_we_s = (cnt_q != 4'd0);
        if (cnt_q < 4'd8) iaddr_d = tap_addr(pix_q, cnt_nx_s);
        if (cnt_q == 4'd9) begin
          state_d = S_CONV;  cnt_d = 4'd0;
        end
      end
      S_CONV: begin
        state_d = S_WR0;  cwr_d = 1'b1;  csel_d = 1'b0;
        caddr_wr_d = pix_q;  cdata_wr_d = relu_sat(acc_s);
      end
      S_WR0: begin
        cnt_d = 4'd0;
        if (pix_q != {AW{1'b1}}) begin
          state_d = S_FETCH;  pix_d = pix_q + AW'(1);
          iaddr_d = tap_addr(pix_q + AW'(1), 4'd0);
        end else if (POOL_EN) begin
          state_d = S_PFETCH;  crd_d = 1'b1;  caddr_rd_d = pool_addr(pout_q, 2'd0);
        end else begin
          state_d = S_DONE;
        end
      end
      S_PFETCH: begin
        cnt_d = cnt_nx_s;
        if (cnt_q < 4'd3) begin
          crd_d = 1'b1;  caddr_rd_d = pool_addr(pout_q, cnt_nx_s[1:0]);
        end
        if (cnt_q != 4'd0) max_d = mx_s;
        if (cnt_q == 4'd4) begin
          state_d = S_PWR;  cnt_d = 4'd0;  cwr_d = 1'b1;  csel_d = 1'b1;
          caddr_wr_d = {2'b00, pout_q};  cdata_wr_d = round_up(mx_s);
        end
      end
      S_PWR: begin
        csel_d = 1'b0;
        if (pout_q != {PW{1'b1}}) begin
          state_d = S_PFETCH;  pout_d = pout_q + PW'(1);  crd_d = 1'b1;
          caddr_rd_d = pool_addr(pout_q + PW'(1), 2'd0);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;  busy_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;  busy_d = 1'b0;
      end
    endcase
  end

  // State, counters, taps and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  cnt_q <= '0;  pix_q <= '0;  pout_q <= '0;  busy_q <= 1'b0;
      iaddr_q <= '0;  cwr_q <= 1'b0;  caddr_wr_q <= '0;  cdata_wr_q <= '0;
      crd_q <= 1'b0;  caddr_rd_q <= '0;  csel_q <= 1'b0;  max_q <= '0;
      for (int i = 0; i < 9; i++) taps_q[i] <= '0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  pix_q <= pix_d;  pout_q <= pout_d;  busy_q <= busy_d;
      iaddr_q <= iaddr_d;  cwr_q <= cwr_d;  caddr_wr_q <= caddr_wr_d;  cdata_wr_q <= cdata_wr_d;
      crd_q <= crd_d;  caddr_rd_q <= caddr_rd_d;  csel_q <= csel_d;  max_q <= max_d;
      if (tap_we_s) taps_q[cnt_q - 4'd1] <= idata;
    end
  end

  assign busy     = busy_q;
  assign iaddr    = iaddr_q;
  assign cwr      = cwr_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;
  assign crd      = crd_q;
  assign caddr_rd = caddr_rd_q;
  assign csel     = csel_q;
endmodule

// File: tb/tb_atconv_pool_param.sv
// Scoreboard bench: a 16x16 dilation-2 pooled instance and a 16x16
// dilation-1 instance without pooling, both fed from a shared image array.
module tb_atconv_pool_param;
  typedef struct { bit csel; int addr; int data; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_ready = 1'b0, b_ready = 1'b0;
  logic a_busy, a_cwr, a_crd, a_csel, b_busy, b_cwr, b_crd, b_csel;
  logic [7:0] a_iaddr, a_caddr_wr, a_caddr_rd, b_iaddr, b_caddr_wr, b_caddr_rd;
  logic [12:0] a_idata = '0, a_cdata_rd = '0, a_cdata_wr;
  logic [12:0] b_idata = '0, b_cdata_rd = '0, b_cdata_wr;
  logic [12:0] a_mem0 [256];
  logic [12:0] a_mem1 [64];
  logic [12:0] b_mem0 [256];
  int img [256];
  wr_t exp_q [$];
  int checks = 0, errors = 0, overlap = 0, extra_wr = 0;

  always #5 clk = ~clk;

  atconv_pool_param #(.IMG_LOG2(4), .DATA_W(13), .DIL(2), .BIAS(-12), .POOL_EN(1'b1)) u_a (
    .clk(clk), .reset(rst), .ready(a_ready), .busy(a_busy), .iaddr(a_iaddr), .idata(a_idata),
    .cwr(a_cwr), .caddr_wr(a_caddr_wr), .cdata_wr(a_cdata_wr), .crd(a_crd),
    .caddr_rd(a_caddr_rd), .cdata_rd(a_cdata_rd), .csel(a_csel));

  atconv_pool_param #(.IMG_LOG2(4), .DATA_W(13), .DIL(1), .BIAS(-12), .POOL_EN(1'b0)) u_b (
    .clk(clk), .reset(rst), .ready(b_ready), .busy(b_busy), .iaddr(b_iaddr), .idata(b_idata),
    .cwr(b_cwr), .caddr_wr(b_caddr_wr), .cdata_wr(b_cdata_wr), .crd(b_crd),
    .caddr_rd(b_caddr_rd), .cdata_rd(b_cdata_rd), .csel(b_csel));

  // Image ROM and result memories, one-cycle read latency.
  always @(posedge clk) begin
    a_idata <= 13'(img[a_iaddr]);
    b_idata <= 13'(img[b_iaddr]);
    if (a_cwr && !a_csel) a_mem0[a_caddr_wr] <= a_cdata_wr;
    if (a_cwr && a_csel) a_mem1[a_caddr_wr[5:0]] <= a_cdata_wr;
    if (a_crd) a_cdata_rd <= a_mem0[a_caddr_rd];
    if (b_cwr && !b_csel) b_mem0[b_caddr_wr] <= b_cdata_wr;
    if (b_crd) b_cdata_rd <= b_mem0[b_caddr_rd];
  end

  task automatic check_val(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_check(input logic csel, input int addr, input int data);
    wr_t e;
    if (exp_q.size() == 0) begin
      extra_wr++;
    end else begin
      e = exp_q.pop_front();
      check_val(e.csel ? "l1_addr" : "l0_addr", addr, e.addr);
      check_val("wr_csel", int'(csel), int'(e.csel));
      check_val(e.csel ? "l1_data" : "l0_data", data, e.data);
    end
  endtask

  // Write monitor and cwr/crd exclusivity.
  always @(negedge clk) begin
    if (a_cwr) sb_check(a_csel, int'(a_caddr_wr), int'(a_cdata_wr));
    if (b_cwr) sb_check(b_csel, int'(b_caddr_wr), int'(b_cdata_wr));
    if ((a_cwr && a_crd) || (b_cwr && b_crd)) overlap++;
  end

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  function automatic int px(input int r, input int c);
    return img[clampc(r) * 16 + clampc(c)];
  endfunction

  task automatic build_exp(input int d, input bit pool);
    int l0 [256];
    int acc, m;
    wr_t e;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        acc = px(r, c) - (px(r-d, c-d) >>> 4) - (px(r-d, c+d) >>> 4)
            - (px(r+d, c-d) >>> 4) - (px(r+d, c+d) >>> 4)
            - (px(r-d, c) >>> 3) - (px(r+d, c) >>> 3)
            - (px(r, c-d) >>> 2) - (px(r, c+d) >>> 2) - 12;
        if (acc < 0) acc = 0;
        if (acc > 4095) acc = 4095;
        l0[r*16+c] = acc;
        e.csel = 1'b0; e.addr = r*16 + c; e.data = acc;
        exp_q.push_back(e);
      end
    end
    if (pool) begin
      for (int pr = 0; pr < 8; pr++) begin
        for (int pc = 0; pc < 8; pc++) begin
          m = l0[(2*pr)*16 + 2*pc];
          if (l0[(2*pr)*16 + 2*pc+1] > m) m = l0[(2*pr)*16 + 2*pc+1];
          if (l0[(2*pr+1)*16 + 2*pc] > m) m = l0[(2*pr+1)*16 + 2*pc];
          if (l0[(2*pr+1)*16 + 2*pc+1] > m) m = l0[(2*pr+1)*16 + 2*pc+1];
          if (m % 16 != 0) m = m - (m % 16) + 16;
          if (m > 4095) m = 4080;
          e.csel = 1'b1; e.addr = pr*8 + pc; e.data = m;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_job(input int which, input int exp_span);
    int cyc;
    @(negedge clk);
    if (which == 0) a_ready = 1'b1; else b_ready = 1'b1;
    @(negedge clk);
    a_ready = 1'b0; b_ready = 1'b0;
    cyc = 0;
    while (((which == 0) ? a_busy : b_busy) && cyc < 6000) begin
      cyc++;
      @(negedge clk);
    end
    check_val("busy_span", cyc + 1, exp_span);
    check_val("sb_drained", exp_q.size(), 0);
    check_val("idle_cwr", int'((which == 0) ? a_cwr : b_cwr), 0);
  endtask

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 256; i++) img[i] = int'($urandom_range(hi - lo)) + lo;
  endtask

  localparam int SPAN_A = 1 + 256*12 + 64*6 + 1;
  localparam int SPAN_B = 1 + 256*12 + 1;

  initial begin
    int popped;
    for (int i = 0; i < 256; i++) img[i] = 0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(a_busy), 0);
    check_val("rst_cwr", int'(a_cwr), 0);
    check_val("rst_crd", int'(a_crd), 0);
    check_val("rst_csel", int'(a_csel), 0);
    check_val("rst_iaddr", int'(a_iaddr), 0);
    check_val("rst_caddr", int'(a_caddr_wr) + int'(a_caddr_rd) + int'(a_cdata_wr), 0);
    rst = 1'b0;

    // all-zero image
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    // constant 1.0
    for (int i = 0; i < 256; i++) img[i] = 16;
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    // single pixel at the centre
    for (int i = 0; i < 256; i++) img[i] = 0;
    img[8*16+8] = 160;
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    check_val("peak_l0", int'(a_mem0[8*16+8]), 148);
    check_val("peak_nbr", int'(a_mem0[6*16+8]), 0);
    check_val("peak_l1", int'(a_mem1[4*8+4]), 160);
    // negative taps shift arithmetically
    img[8*16+8] = 0;
    img[6*16+6] = -16; img[6*16+8] = -16; img[6*16+10] = -16; img[8*16+6] = -16;
    img[8*16+10] = -16; img[10*16+6] = -16; img[10*16+8] = -16; img[10*16+10] = -16;
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    check_val("ashift_l0", int'(a_mem0[8*16+8]), 4);
    // corner replicate padding
    for (int i = 0; i < 256; i++) img[i] = 0;
    img[0] = 256;
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    check_val("corner_l0", int'(a_mem0[0]), 132);
    check_val("corner_l1", int'(a_mem1[0]), 144);
    // saturation of layer 0 and of round-up
    for (int i = 0; i < 256; i++) img[i] = -4096;
    img[8*16+8] = 4095;
    build_exp(2, 1'b1);  run_job(0, SPAN_A);
    check_val("sat_l0", int'(a_mem0[8*16+8]), 4095);
    check_val("sat_l1", int'(a_mem1[4*8+4]), 4080);
    // random full-range image
    fill(-4096, 4095);
    build_exp(2, 1'b1);  run_job(0, SPAN_A);

    // abort during FETCH of pixel 100, then rerun
    fill(-256, 1023);
    build_exp(2, 1'b1);
    @(negedge clk); a_ready = 1'b1;
    @(negedge clk); a_ready = 1'b0;
    repeat (12*100 + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy", int'(a_busy), 0);
    check_val("abort_cwr", int'(a_cwr), 0);
    check_val("abort_csel", int'(a_csel), 0);
    check_val("abort_crd", int'(a_crd), 0);
    popped = 256 + 64 - exp_q.size();
    check_val("abort_writes", popped, 100);
    exp_q.delete();
    repeat (30) @(negedge clk);
    check_val("abort_stays_idle", int'(a_busy), 0);
    build_exp(2, 1'b1);  run_job(0, SPAN_A);

    // dilation 1, no pooling
    fill(-1024, 2047);
    build_exp(1, 1'b0);  run_job(1, SPAN_B);
    for (int i = 0; i < 256; i++) img[i] = 0;
    img[5*16+5] = 400;
    build_exp(1, 1'b0);  run_job(1, SPAN_B);
    check_val("d1_peak", int'(b_mem0[5*16+5]), 388);

    check_val("no_wr_rd_overlap", overlap, 0);
    check_val("extra_writes", extra_wr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
